// File: rtl/mux_bus_arbiter_if.sv
// rtl/mux_bus_arbiter_if.sv - requester/downstream bus bundle for mux_bus_arbiter
interface mux_bus_arbiter_if #(
  parameter int BITS = 16
);
  logic            req0_valid;
  logic [BITS-1:0] req0_data;
  logic            req0_last;
  logic            req0_ready;
  logic            req1_valid;
  logic [BITS-1:0] req1_data;
  logic            req1_last;
  logic            req1_ready;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic            out_last;
  logic            out_ready;
  logic            select;
  logic [1:0]      grant;
  logic            busy;

  // arbiter side
  modport master (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_last, select, grant, busy
  );

  // requesters/downstream side
  modport slave (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_last, select, grant, busy
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - two-requester round-robin burst arbiter with data steering
// Optional stall-timeout grant revocation enabled by defining ARB_TIMEOUT_EN.
module mux_bus_arbiter #(
  parameter int BITS    = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  mux_bus_arbiter_if.master bus
`ifdef ARB_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state, state_nx;
  logic   last_owner, last_owner_nx;
  logic   cur_valid, cur_last, other_valid, owner;
  logic   xfer, to_hit;

  always_comb begin
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_last   = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    cur_valid      = 1'b0;
    cur_last       = 1'b0;
    other_valid    = 1'b0;
    owner          = 1'b0;
    case (state)
      OWN0: begin
        bus.out_valid  = bus.req0_valid;
        bus.out_data   = bus.req0_data;
        bus.out_last   = bus.req0_last;
        bus.req0_ready = bus.out_ready;
        cur_valid      = bus.req0_valid;
        cur_last       = bus.req0_last;
        other_valid    = bus.req1_valid;
        owner          = 1'b0;
      end
      OWN1: begin
        bus.out_valid  = bus.req1_valid;
        bus.out_data   = bus.req1_data;
        bus.out_last   = bus.req1_last;
        bus.req1_ready = bus.out_ready;
        cur_valid      = bus.req1_valid;
        cur_last       = bus.req1_last;
        other_valid    = bus.req0_valid;
        owner          = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer = cur_valid && bus.out_ready;

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] stall_cnt;
  assign to_hit = (state != IDLE) && !xfer && (stall_cnt == TO_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    case (state)
      IDLE: begin
        // last_owner resets to 1 so requester 0 wins the first tie
        if (bus.req0_valid && bus.req1_valid) state_nx = last_owner ? OWN0 : OWN1;
        else if (bus.req0_valid)              state_nx = OWN0;
        else if (bus.req1_valid)              state_nx = OWN1;
      end
      default: begin
        if (xfer && cur_last) begin
          last_owner_nx = owner;
          if (other_valid)    state_nx = owner ? OWN0 : OWN1;
          else if (cur_valid) state_nx = state;
          else                state_nx = IDLE;
        end else if (to_hit) begin
          last_owner_nx = owner;
          state_nx      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      bus.grant  <= 2'b00;
      bus.select <= 1'b0;
      bus.busy   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_cnt  <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      bus.grant  <= {state_nx == OWN1, state_nx == OWN0};
      bus.select <= (state_nx == OWN1);
      bus.busy   <= (state_nx != IDLE);
`ifdef ARB_TIMEOUT_EN
      timeout    <= to_hit;
      if (state_nx != state || xfer || state == IDLE) stall_cnt <= '0;
      else                                            stall_cnt <= stall_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb/tb_mux_bus_arbiter.sv - scoreboard bench for mux_bus_arbiter
module tb_mux_bus_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        src;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  int    total = 0;
  int    bad = 0;
  logic  ordy = 1'b1;
  beat_t q0[$], q1[$], sb[$];
  logic [1:0] s_grant;
  logic  s_busy, s_ovalid, s_r0, s_r1, s_xfer, s_to;

  mux_bus_arbiter_if #(.BITS(16)) bus ();

`ifdef ARB_TIMEOUT_EN
  logic timeout;
  mux_bus_arbiter #(.BITS(16), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master), .timeout(timeout));
`else
  mux_bus_arbiter #(.BITS(16), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic [15:0] d, input logic l);
    beat_t b;
    b = '{data: d, last: l, src: r};
    if (r) q1.push_back(b);
    else   q0.push_back(b);
    sb.push_back(b);
  endtask

  // One clock cycle: drive sources from their queues, sample at negedge, score any transfer.
  task automatic step();
    beat_t e;
    bus.req0_valid = (q0.size() > 0);
    bus.req0_data  = (q0.size() > 0) ? q0[0].data : 16'h0;
    bus.req0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
    bus.req1_valid = (q1.size() > 0);
    bus.req1_data  = (q1.size() > 0) ? q1[0].data : 16'h0;
    bus.req1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
    bus.out_ready  = ordy;
    @(negedge clk);
    s_grant  = bus.grant;
    s_busy   = bus.busy;
    s_ovalid = bus.out_valid;
    s_r0     = bus.req0_ready;
    s_r1     = bus.req1_ready;
    s_xfer   = bus.out_valid && bus.out_ready;
`ifdef ARB_TIMEOUT_EN
    s_to     = timeout;
`else
    s_to     = 1'b0;
`endif
    if (s_xfer) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow: observed=transfer expected=no_transfer");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_last", bus.out_last, e.last);
        chk("select_src", bus.select, e.src);
        chk("grant_src", bus.grant, e.src ? 2'b10 : 2'b01);
      end
    end
    if (bus.req0_valid && bus.req0_ready) void'(q0.pop_front());
    if (bus.req1_valid && bus.req1_ready) void'(q1.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
    bus.out_ready  = 1'b1;
    #2;
    // reset state with requests pending
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_select", bus.select, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);

    // single 3-beat burst from requester 0
    do_reset();
    push(1'b0, 16'h1111, 1'b0);
    push(1'b0, 16'h2222, 1'b0);
    push(1'b0, 16'h3333, 1'b1);
    step();
    chk("t1_c0_grant", s_grant, 2'b00);
    chk("t1_c0_xfer", s_xfer, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t1_grant", s_grant, 2'b01);
      chk("t1_xfer", s_xfer, 1'b1);
      chk("t1_ready1", s_r1, 1'b0);
    end
    step();
    chk("t1_c4_out_valid", s_ovalid, 1'b0);
    chk("t1_sb_drained", sb.size(), 0);

    // both valid from reset, 2-beat bursts, no bubble
    do_reset();
    push(1'b0, 16'hA000, 1'b0);
    push(1'b0, 16'hA001, 1'b1);
    push(1'b1, 16'hB000, 1'b0);
    push(1'b1, 16'hB001, 1'b1);
    step();
    chk("t2_c0_grant", s_grant, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_xfer", s_xfer, 1'b1);
      chk("t2_grant", s_grant, (i <= 2) ? 2'b01 : 2'b10);
    end

    // single-beat bursts alternate every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 16'hC000 + 16'(i), 1'b1);
      push(1'b1, 16'hD000 + 16'(i), 1'b1);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_grant", s_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_xfer", s_xfer, 1'b1);
    end

    // requester 1 stalled mid-burst while requester 0 waits
    do_reset();
    push(1'b1, 16'hE000, 1'b0);
    push(1'b1, 16'hE001, 1'b0);
    push(1'b1, 16'hE002, 1'b1);
    step();
    step();
    chk("t4_first_beat", s_xfer, 1'b1);
    push(1'b0, 16'hF000, 1'b1);
    ordy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_stall_grant", s_grant, 2'b10);
      chk("t4_stall_ready0", s_r0, 1'b0);
      chk("t4_stall_busy", s_busy, 1'b1);
    end
    ordy = 1'b1;
    step();
    chk("t4_resume_xfer", s_xfer, 1'b1);
    step();
    chk("t4_last_xfer", s_xfer, 1'b1);
    step();
    chk("t4_handover", s_grant, 2'b01);
    chk("t4_sb_drained", sb.size(), 0);

    // reset mid-burst of requester 0
    do_reset();
    push(1'b0, 16'h5A00, 1'b0);
    push(1'b0, 16'h5A01, 1'b0);
    push(1'b0, 16'h5A02, 1'b1);
    push(1'b1, 16'h5B00, 1'b1);
    step();
    step();
    chk("t5_first_beat", s_xfer, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_grant", bus.grant, 2'b00);
    chk("t5_rst_ready0", bus.req0_ready, 1'b0);
    chk("t5_rst_out_valid", bus.out_valid, 1'b0);
    q0.delete();
    sb.delete();
    sb.push_back('{data: 16'h5B00, last: 1'b1, src: 1'b1});
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("t5_idle_grant", s_grant, 2'b00);
    step();
    chk("t5_req1_grant", s_grant, 2'b10);
    chk("t5_req1_xfer", s_xfer, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // stall timeout revokes requester 0, pending requester 1 takes over
    do_reset();
    ordy = 1'b0;
    push(1'b1, 16'h7B00, 1'b1);
    push(1'b0, 16'h7A00, 1'b0);
    push(1'b0, 16'h7A01, 1'b1);
    step();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("to_stall_grant", s_grant, 2'b01);
      chk("to_no_pulse", s_to, 1'b0);
    end
    step();
    chk("to_pulse", s_to, 1'b1);
    chk("to_idle_grant", s_grant, 2'b00);
    ordy = 1'b1;
    step();
    chk("to_req1_grant", s_grant, 2'b10);
    chk("to_req1_xfer", s_xfer, 1'b1);
    step();
    step();
    chk("to_sb_drained", sb.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_bus_arbiter.md
Name: mux_bus_arbiter

Overview:
- Two-requester round-robin arbiter that shares one downstream bus port between two burst sources.
- Drives the select line of the existing 2:1 word mux in the RISC datapath.
- Also contains the equivalent internal data steering, so the block can drive the port directly.
- Grants are held for a whole burst (through the beat flagged last), then re-arbitrated with no idle bubble.

Parameters:
- BITS, 16, data word width for both requesters and the output.
- TIMEOUT, 255, stall cycles before grant revocation (used only with the optional feature); minimum 1.
- TO_W, 8, width of the stall counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a beat.
- req0_data  in  BITS  requester 0 beat data.
- req0_last  in  1  final beat of requester 0 burst.
- req0_ready  out  1  beat of requester 0 accepted this cycle.
- req1_valid / req1_data / req1_last / req1_ready  in/in/in/out  1/BITS/1/1  same meanings for requester 1.
- out_valid  out  1  granted requester's valid.
- out_data  out  BITS  granted requester's data.
- out_last  out  1  granted requester's last.
- out_ready  in  1  downstream accepts a beat.
- select  out  1  mux select: 0 = requester 0, 1 = requester 1.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  grant held (state != IDLE).
- timeout  out  1  one-cycle pulse on grant revocation (present only with ARB_TIMEOUT_EN).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=00, select=0, busy=0, last_owner=1 (so requester 0 wins the first tie).
  - Outputs at reset: out_valid=0, both readies 0, timeout=0.
- States: IDLE, OWN0, OWN1. grant, select and busy are registered, decoded from state.
- IDLE:
  - out_valid=0, out_last=0, out_data=0, both readies 0.
  - One valid: next state is OWNn for that requester.
  - Both valid: next state is OWN(~last_owner).
  - Arbitration latency is 1 cycle from valid to grant. No beat transfers in IDLE.
- OWNn:
  - out_valid=reqn_valid, out_data=reqn_data, out_last=reqn_last.
  - reqn_ready=out_ready; the other requester's ready=0. All combinational, zero-latency passthrough.
  - A beat transfers when reqn_valid && out_ready.
- End of burst (transfer with reqn_last=1): last_owner<=n. Next state, in priority order:
  - other requester valid -> OWN(other);
  - else reqn_valid still asserted that cycle -> OWNn (next burst);
  - else IDLE.
  - Back-to-back bursts from alternating requesters sustain 1 beat/cycle.
- Mid-burst behaviour:
  - Grant is held until the last-beat transfer, even if reqn_valid drops or out_ready stalls indefinitely.
  - The other requester is never granted mid-burst.
- Single-beat burst (valid and last together) is legal: one transfer, then re-arbitrate.
- Requester protocol: once valid is asserted, data/last stay stable until the transfer. The arbiter does not check this.
- select must equal grant[1] in every cycle.
- Reset mid-burst: immediate return to IDLE with all readies 0. The partial burst is discarded; the downstream must tolerate this.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Stall counter (TO_W bits) cleared on entry to OWNn and on every transfer.
  - Increments each OWNn cycle without a transfer.
  - On reaching TIMEOUT: grant revoked, next state IDLE, last_owner<=n, timeout pulses high for 1 cycle.
  - Counter reset value 0.
- Undefined: no counter, no timeout port; grant is held indefinitely.

Test Plan:
- Reset then req0_valid=1 with 3-beat burst 0x1111/0x2222/0x3333 (last on 3rd), out_ready=1 -> grant=01 at cycle 1, beats on cycles 1-3, state IDLE at cycle 4, select=0 throughout.
- Both valid from reset, each 2-beat burst, out_ready=1 -> req0 beats at cycles 1-2, req1 beats at cycles 3-4, no bubble, select 0->1 at cycle 3.
- Both continuously valid with 1-beat bursts -> grant alternates 01,10,01,10 every cycle, out_data alternates the sources.
- req1 owns a burst, out_ready=0 for 10 cycles mid-burst while req0_valid=1 -> req0_ready stays 0, grant stays 10, resumes with req1 data when out_ready=1.
- Assert reset_n=0 mid-burst of req0 -> same cycle grant=00, req0_ready=0, out_valid=0; after release, req1 waiting is granted next cycle.
- ARB_TIMEOUT_EN, TIMEOUT=4: req0 granted, out_ready=0 -> timeout pulses after 4 stall cycles, state IDLE, pending req1 granted the next cycle.
